// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer: record layout, filter modes, FSM states
// and the retirement filter.
package ibex_trace_pkg;

   typedef enum logic [1:0] {
      MODE_ALL  = 2'd0,
      MODE_TRAP = 2'd1,
      MODE_MEM  = 2'd2,
      MODE_RD   = 2'd3
   } trace_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CAPTURE   = 2'd1,
      ST_POST_TRIG = 2'd2,
      ST_FROZEN    = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
      logic        intr;
      logic [1:0]  mode;
   } trace_rec_t;

   function automatic logic filter_pass(input trace_mode_e mode,
                                        input logic        trap,
                                        input logic        intr,
                                        input logic [3:0]  rmask,
                                        input logic [3:0]  wmask,
                                        input logic [4:0]  rd_addr);
      logic pass;
      pass = 1'b0;
      case (mode)
         MODE_ALL:  pass = 1'b1;
         MODE_TRAP: pass = trap | intr;
         MODE_MEM:  pass = |(rmask | wmask);
         MODE_RD:   pass = (rd_addr != 5'd0);
         default:   pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Synchronous trace FIFO. When full, a lone push either drops the new record or,
// with overwrite_i set, evicts the oldest one; drop_o flags both cases.
module ibex_trace_fifo
   import ibex_trace_pkg::*;
#(
   parameter int unsigned Depth = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  trace_rec_t                   data_i,
   input  logic                         overwrite_i,
   input  logic                         pop_i,
   output trace_rec_t                   data_o,
   output logic                         valid_o,
   output logic [$clog2(Depth+1)-1:0]   level_o,
   output logic                         drop_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = $clog2(Depth + 1);

   trace_rec_t            mem [Depth];
   logic [PtrW-1:0]       wr_ptr;
   logic [PtrW-1:0]       rd_ptr;
   logic [LvlW-1:0]       level;
   logic                  empty;
   logic                  full;
   logic                  pop_eff;
   logic                  wr_en;
   logic                  evict;

   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
      empty   = (level == '0);
      full    = (level == LvlW'(Depth));
      pop_eff = pop_i && !empty;
      wr_en   = push_i && (!full || pop_eff || overwrite_i);
      evict   = push_i && full && !pop_eff && overwrite_i;
      drop_o  = push_i && full && !pop_eff;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop_eff || evict) rd_ptr <= rd_ptr + PtrW'(1);
         if (wr_en && !pop_eff && !evict) begin
            level <= level + LvlW'(1);
         end else if (pop_eff && !push_i) begin
            level <= level - LvlW'(1);
         end
      end
   end

   // NOTE: storage is deliberately unreset; reads are masked by valid_o, so its contents never leak out.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= data_i;
   end

   assign valid_o = !empty;
   assign data_o  = empty ? '0 : mem[rd_ptr];
   assign level_o = level;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: filters retired instructions into a FIFO, with a
// PC trigger that freezes capture a programmable number of records later.
module ibex_rvfi_trace_buffer
   import ibex_trace_pkg::*;
#(
   parameter int unsigned Depth    = 16,
   parameter int unsigned DropCntW = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic [1:0]                   mode_i,
   input  logic                         wrap_i,
   input  logic                         trig_en_i,
   input  logic [31:0]                  trig_pc_i,
   input  logic [15:0]                  post_trig_i,
   input  logic                         rvfi_valid,
   input  logic [31:0]                  rvfi_insn,
   input  logic [31:0]                  rvfi_pc_rdata,
   input  logic [31:0]                  rvfi_rd_wdata,
   input  logic                         rvfi_trap,
   input  logic                         rvfi_intr,
   input  logic [1:0]                   rvfi_mode,
   input  logic [4:0]                   rvfi_rd_addr,
   input  logic [3:0]                   rvfi_mem_rmask,
   input  logic [3:0]                   rvfi_mem_wmask,
   output trace_rec_t                   rec_o,
   output logic                         rec_valid_o,
   input  logic                         rec_ready_i,
   output logic [$clog2(Depth+1)-1:0]   level_o,
   output logic [DropCntW-1:0]          drop_cnt_o,
   output logic [1:0]                   state_o,
   output logic                         frozen_o
);

   trace_state_e state;
   trace_rec_t   rec_in;
   logic [15:0]  post_cnt;
   logic         accept;
   logic         trig_hit;
   logic         fifo_drop;

   assign rec_in = '{pc:       rvfi_pc_rdata,
                     insn:     rvfi_insn,
                     rd_addr:  rvfi_rd_addr,
                     rd_wdata: rvfi_rd_wdata,
                     trap:     rvfi_trap,
                     intr:     rvfi_intr,
                     mode:     rvfi_mode};

   assign accept = ((state == ST_CAPTURE) || (state == ST_POST_TRIG)) && rvfi_valid &&
                   filter_pass(trace_mode_e'(mode_i), rvfi_trap, rvfi_intr,
                               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_rd_addr);

   assign trig_hit = trig_en_i && (rvfi_pc_rdata == trig_pc_i);

   // The trigger record is stored; post_cnt counts the records still to follow it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         post_cnt <= '0;
      end else if (!enable_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state <= ST_CAPTURE;
            ST_CAPTURE: begin
               if (accept && trig_hit) begin
                  post_cnt <= post_trig_i;
                  state    <= (post_trig_i == 16'd0) ? ST_FROZEN : ST_POST_TRIG;
               end
            end
            ST_POST_TRIG: begin
               if (accept) begin
                  post_cnt <= post_cnt - 16'd1;
                  if (post_cnt == 16'd1) state <= ST_FROZEN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_o <= '0;
      end else if (fifo_drop && (drop_cnt_o != '1)) begin
         drop_cnt_o <= drop_cnt_o + DropCntW'(1);
      end
   end

   ibex_trace_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept),
      .data_i      (rec_in),
      .overwrite_i (wrap_i),
      .pop_i       (rec_ready_i),
      .data_o      (rec_o),
      .valid_o     (rec_valid_o),
      .level_o     (level_o),
      .drop_o      (fifo_drop)
   );

   assign state_o  = state;
   assign frozen_o = (state == ST_FROZEN);

endmodule
